// File: rtl/plis_pkg.sv
// Shared types and helpers for the bit-serial arithmetic units.
package plis_pkg;

    typedef enum logic [1:0] {SUB_IDLE, SUB_RUN, SUB_DONE} sub_state_t;

    // Bits needed to hold values 0..value-1; used to size the bit counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/one_bit_subtractor.sv
// Combinational full-subtractor cell: d = x - y - bin, bout is the borrow out.
module one_bit_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed overflow flag enabled by defining BIT_SERIAL_SUB_OVF_EN.
module bit_serial_subtractor
    import plis_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CW = clog2(WIDTH + 1);

    sub_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    count;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] res_next;
    logic             last;

    one_bit_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (br),
        .d    (d),
        .bout (bout)
    );

    // res_next already includes the bit being produced this cycle, so the
    // final value can be captured into diff on the same edge we leave RUN.
    assign res_next = {d, res_sr[WIDTH-1:1]};
    assign last     = (count == CW'(WIDTH - 1));

`ifdef BIT_SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SUB_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                SUB_IDLE, SUB_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SUB_RUN;
`ifdef BIT_SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= SUB_IDLE;
                    end
                end
                SUB_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= bout;
                    count  <= count + CW'(1);
                    if (last) begin
                        state      <= SUB_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= bout;
`ifdef BIT_SERIAL_SUB_OVF_EN
                        ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: state <= SUB_IDLE;
            endcase
        end
    end

endmodule
